// File: rtl/efi_spi_master.sv
// efi_spi_master: mode-0 SPI initiator for fixed-length frames; define EFI_SPI_MISO_SYNC_EN to add a 2-flop miso synchronizer
module efi_spi_master #(
  parameter int FRAME_BITS = 24,
  parameter int HALF = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [7:0] HM = 8'(HALF - 1);
  localparam logic [BW-1:0] NB = BW'(FRAME_BITS);
  localparam logic [BW-1:0] LB = BW'(FRAME_BITS - 1);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr;
  logic miso_s, half_end;
`ifdef EFI_SPI_MISO_SYNC_EN
  localparam logic [7:0] SAMPLE = HM;
  logic [1:0] miso_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) miso_q <= '0;
    else miso_q <= {miso_q[0], miso};
  assign miso_s = miso_q[1];
  if (HALF < 3) begin : g_half_chk
    $error("efi_spi_master: HALF must be >= 3 with EFI_SPI_MISO_SYNC_EN");
  end
`else
  localparam logic [7:0] SAMPLE = 8'd0;
  assign miso_s = miso;
`endif
  assign half_end = cnt == HM;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || half_end) ? 8'd0 : cnt + 8'd1;
      if (state == HIGH && cnt == SAMPLE) rx_sr <= {rx_sr[FRAME_BITS-2:0], miso_s};
      case (state)
        IDLE: if (start) begin
          tx_sr   <= tx_data;
          bit_cnt <= '0;
          mosi    <= tx_data[FRAME_BITS-1];
          cs      <= 1'b0;
          busy    <= 1'b1;
          state   <= SETUP;
        end
        SETUP: if (half_end) begin
          sck   <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (half_end) begin
          sck     <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
          state   <= LOW;
          if (bit_cnt != LB) begin
            tx_sr <= tx_sr << 1;
            mosi  <= tx_sr[FRAME_BITS-2];
          end
        end
        LOW: if (half_end) begin
          if (bit_cnt == NB) begin
            cs      <= 1'b1;
            done    <= 1'b1;
            rx_data <= rx_sr;
            state   <= GAP;
          end else begin
            sck   <= 1'b1;
            state <= HIGH;
          end
        end
        GAP: if (half_end) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
